// File: rtl/fifo_early_ready_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_early_ready_if
// Description : Handshake and status bundle of the early-ready receive buffer.
//               slave  : buffer side (drives i_rdy, o_en, o_data, level,
//                        overflow)
//               master : environment side (drives i_en, i_data, o_rdy)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_early_ready_if #(
    parameter int DW = 8,
    parameter int AW = 10
) ();
    logic          i_rdy;
    logic          i_en;
    logic [DW-1:0] i_data;
    logic          o_rdy;
    logic          o_en;
    logic [DW-1:0] o_data;
    logic [AW:0]   level;
    logic          overflow;

    modport slave (
        output i_rdy,
        input  i_en,
        input  i_data,
        input  o_rdy,
        output o_en,
        output o_data,
        output level,
        output overflow
    );

    modport master (
        input  i_rdy,
        output i_en,
        output i_data,
        output o_rdy,
        input  o_en,
        input  o_data,
        input  level,
        input  overflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram_sdp
// Description : Simple dual-port RAM, DW x 2**AW, one write port and one
//               registered read port. Kept separate so a vendor macro can be
//               dropped in without touching the buffer control logic.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (sampled every cycle)
//   rdata : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram_sdp #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule
`default_nettype wire

// File: rtl/fifo_early_ready.sv
`default_nettype none
// ============================================================================
// Module      : fifo_early_ready
// Description : Receive-path elastic buffer. i_rdy drops while SKID free
//               slots remain, so a producer that keeps pushing for up to SKID
//               words after seeing i_rdy=0 still loses nothing. Output side is
//               a show-ahead AXI-stream style valid/ready port.
//   clk      : clock
//   rst      : synchronous active-high reset
//   bus      : fifo_early_ready_if.slave (i_rdy/i_en/i_data in,
//              o_en/o_rdy/o_data out, level, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_early_ready #(
    parameter int DW   = 8,
    parameter int AW   = 10,
    parameter int SKID = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    fifo_early_ready_if.slave bus
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_V  = DEPTH[AW:0];
    // i_rdy = (DEPTH - occupancy) > SKID  <=>  occupancy < DEPTH - SKID
    localparam int          THRESH   = DEPTH - SKID;
    localparam logic [AW:0] THRESH_V = THRESH[AW:0];

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        o_en_q;
    logic        i_rdy_q;
    logic [AW:0] level_q;
    logic        overflow_q;

    logic [AW:0] occ;
    logic        full;
    logic        do_write;
    logic        pop;
    logic [AW:0] wptr_next;
    logic [AW:0] rptr_next;
    logic [AW:0] occ_next;

    always_comb begin
        occ       = wptr - rptr;
        // full is judged before any pop in the same cycle (conservative)
        full      = (occ == DEPTH_V);
        do_write  = bus.i_en & ~full;
        pop       = o_en_q & bus.o_rdy;
        wptr_next = wptr + {{AW{1'b0}}, do_write};
        rptr_next = rptr + {{AW{1'b0}}, pop};
        occ_next  = wptr_next - rptr_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            o_en_q     <= 1'b0;
            i_rdy_q    <= 1'b1;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr       <= wptr_next;
            rptr       <= rptr_next;
            // Compare against the registered write pointer: a word written
            // at this edge is only presented after the next edge, when the
            // RAM read port can already see it (no write-through bypass).
            o_en_q     <= (rptr_next != wptr);
            i_rdy_q    <= (occ_next < THRESH_V);
            level_q    <= occ_next;
            overflow_q <= overflow_q | (bus.i_en & full);
        end
    end

    // Read address follows rptr_next, so the head word is re-read while the
    // consumer stalls and o_data stays put.
    fifo_ram_sdp #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write & ~rst),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.i_data),
        .raddr (rptr_next[AW-1:0]),
        .rdata (bus.o_data)
    );

    assign bus.o_en     = o_en_q;
    assign bus.i_rdy    = i_rdy_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_early_ready.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_early_ready
// Description : Self-checking bench for fifo_early_ready (AW=4, SKID=3).
//               A reference queue holds the words the buffer should contain;
//               the monitor compares level, flags and head data every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_early_ready;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int SKID  = 3;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_early_ready_if #(.DW(DW), .AW(AW)) bus ();

    fifo_early_ready #(
        .DW   (DW),
        .AW   (AW),
        .SKID (SKID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // ---------------- reference model + monitor ----------------
    logic [DW-1:0] q[$];      // words stored, oldest first
    bit            exp_oen = 1'b0;
    bit            exp_ovf = 1'b0;
    bit            started = 1'b0;

    always @(negedge clk) begin
        int sz;
        bit pop;
        if (started) begin
            chk("level", int'(bus.level), q.size());
            chk("i_rdy", int'(bus.i_rdy), int'((DEPTH - q.size()) > SKID));
            chk("overflow", int'(bus.overflow), int'(exp_ovf));
            chk("o_en", int'(bus.o_en), int'(exp_oen));
            // Head word must be presented (and held) whenever valid.
            if (bus.o_en && exp_oen && q.size() > 0)
                chk("o_data", int'(bus.o_data), int'(q[0]));
        end
        // Apply the upcoming edge to the model.
        if (rst) begin
            q.delete();
            exp_oen = 1'b0;
            exp_ovf = 1'b0;
            started = 1'b1;
        end else if (started) begin
            sz  = q.size();
            pop = exp_oen && bus.o_rdy;
            if (bus.i_en) begin
                if (sz == DEPTH) exp_ovf = 1'b1;
                else             q.push_back(bus.i_data);
            end
            if (pop) void'(q.pop_front());
            // A word becomes visible one edge after it was stored.
            exp_oen = (sz - int'(pop)) > 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit en, input logic [DW-1:0] d, input bit ordy);
        bus.i_en   = en;
        bus.i_data = d;
        bus.o_rdy  = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_en   = 1'b0;
        bus.i_data = '0;
        bus.o_rdy  = 1'b0;
        rst        = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Single word
        step(1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        chk("single_oen_latency", int'(bus.o_en), 0);
        chk("single_level", int'(bus.level), 1);
        step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("single_oen", int'(bus.o_en), 1);
        chk("single_data", int'(bus.o_data), 8'hA5);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Fill with consumer stalled: early ready, skid room, then a drop
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, DW'(8'h40 + i), 1'b0);
            if (i == DEPTH - SKID - 1) begin
                @(negedge clk);
                chk("early_rdy_level", int'(bus.level), DEPTH - SKID);
                chk("early_rdy_low", int'(bus.i_rdy), 0);
            end
            if (i == DEPTH - 1) begin
                @(negedge clk);
                chk("skid_no_ovf", int'(bus.overflow), 0);
            end
        end
        @(negedge clk);
        chk("full_level", int'(bus.level), DEPTH);
        chk("full_ovf", int'(bus.overflow), 1);

        // Drain
        repeat (DEPTH + 4) step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("drained_oen", int'(bus.o_en), 0);
        chk("drained_level", int'(bus.level), 0);

        // Clear overflow, then streaming with pointer wrap
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) step(1'b1, DW'(i), 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // Random traffic with backpressure
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 1)));
        repeat (DEPTH + 4) step(1'b0, 8'h00, 1'b1);

        // Reset mid-burst at level 7
        repeat (7) step(1'b1, DW'($urandom), 1'b0);
        @(negedge clk);
        chk("preburst_level", int'(bus.level), 7);
        rst = 1'b1;
        step(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_oen", int'(bus.o_en), 0);
        chk("rst_irdy", int'(bus.i_rdy), 1);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("post_rst_first", int'(bus.o_data), 8'h3C);
        repeat (4) step(1'b0, 8'h00, 1'b1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
